// File: rtl/fetch_sequencer_if.sv
// Fetch-stage control bundle: hazard/branch requests in, PC/IF-ID controls and
// debug counters out.
interface fetch_sequencer_if #(
  parameter int WORD  = 64,
  parameter int CNT_W = 32
);
  logic             stall_req;
  logic             branch_taken;
  logic [WORD-1:0]  branch_target;
  logic             pc_write;
  logic             pc_src;
  logic             ifid_write;
  logic             ifid_flush;
  logic             fetch_valid;
  logic [WORD-1:0]  redirect_target;
  logic [CNT_W-1:0] fetched_count;
  logic [CNT_W-1:0] bubble_count;
  logic [1:0]       state;

  modport master (
    output stall_req, branch_taken, branch_target,
    input  pc_write, pc_src, ifid_write, ifid_flush, fetch_valid,
           redirect_target, fetched_count, bubble_count, state
  );

  modport slave (
    input  stall_req, branch_taken, branch_target,
    output pc_write, pc_src, ifid_write, ifid_flush, fetch_valid,
           redirect_target, fetched_count, bubble_count, state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: boot wait, run/stall, redirect with refill
// bubbles, plus saturating fetch/bubble counters.
module fetch_sequencer #(
  parameter int WORD         = 64,
  parameter int BOOT_CYCLES  = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic reset,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3} state_t;

  localparam logic [3:0] BOOT_INIT  = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           r_state, w_next;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [WORD-1:0]  r_redirect;
  logic [CNT_W-1:0] r_fetched, r_bubble;
  logic             w_pc_write, w_pc_src, w_ifid_write, w_ifid_flush, w_fetch_valid;
  logic             w_load_tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_cnt   <= BOOT_INIT;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_cnt_nxt     = r_cnt;
    w_pc_write    = 1'b0;
    w_pc_src      = 1'b0;
    w_ifid_write  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_fetch_valid = 1'b0;
    w_load_tgt    = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b1;
        if (r_cnt == 4'd0) w_next = S_RUN;
        else               w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RUN, S_STALL: begin
        // Redirect outranks a stall: the wrong-path fetch is dropped anyway.
        if (bus.branch_taken) begin
          w_pc_write   = 1'b1;
          w_pc_src     = 1'b1;
          w_ifid_write = 1'b1;
          w_ifid_flush = 1'b1;
          w_load_tgt   = 1'b1;
          w_cnt_nxt    = FLUSH_INIT;
          w_next       = S_FLUSH;
        end else if (bus.stall_req) begin
          w_next = S_STALL;
        end else begin
          w_pc_write    = 1'b1;
          w_ifid_write  = 1'b1;
          w_fetch_valid = 1'b1;
          w_next        = S_RUN;
        end
      end
      S_FLUSH: begin
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b1;
        if (r_cnt == 4'd0) w_next = S_RUN;
        else               w_cnt_nxt = r_cnt - 4'd1;
      end
      default: begin
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b1;
        w_next       = S_BOOT;
        w_cnt_nxt    = BOOT_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirect <= '0;
      r_fetched  <= '0;
      r_bubble   <= '0;
    end else begin
      if (w_load_tgt) r_redirect <= bus.branch_target;
      if (w_fetch_valid && (r_fetched != '1)) r_fetched <= r_fetched + 1'b1;
      if (!w_fetch_valid && (r_state != S_BOOT) && (r_bubble != '1)) r_bubble <= r_bubble + 1'b1;
    end
  end

  assign bus.pc_write        = w_pc_write;
  assign bus.pc_src          = w_pc_src;
  assign bus.ifid_write      = w_ifid_write;
  assign bus.ifid_flush      = w_ifid_flush;
  assign bus.fetch_valid     = w_fetch_valid;
  assign bus.redirect_target = r_redirect;
  assign bus.fetched_count   = r_fetched;
  assign bus.bubble_count    = r_bubble;
  assign bus.state           = r_state;
endmodule
